// File: rtl/delay_line_checker.sv
// rtl/delay_line_checker.sv - latency and ramp-sequence checker for a delay line
// Optional macro: DELAY_LINE_CHECKER_STICKY_EN (first tracking mismatch is terminal)
module delay_line_checker #(
  parameter int N       = 10,
  parameter int DELAY   = 5,
  parameter int MAX_LAT = 64,
  parameter int LAT_W   = 7,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [N-1:0]     ref_data,
  input  logic [N-1:0]     dut_data,
  output logic             locked,
  output logic             lat_valid,
  output logic [LAT_W-1:0] lat_value,
  output logic             lat_ok,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] DELAY_C   = LAT_W'(DELAY);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_t           state, state_n;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
  logic [LAT_W-1:0] lat_value_n;
  logic [LAT_W-1:0] k;
  logic [N-1:0]     mark, mark_n;
  logic [N-1:0]     expected, expected_n;
  logic             lat_valid_n, lat_ok_n, err_pulse_n;
  logic [ERR_W-1:0] err_count_n;

  // Lock indication is a pure decode of the tracking state
  assign locked = (state == TRACK);

  // Register all state and outputs; reset wins over ce
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      mark      <= '0;
      expected  <= '0;
      lat_value <= '0;
      lat_valid <= 1'b0;
      lat_ok    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      lat_cnt   <= lat_cnt_n;
      mark      <= mark_n;
      expected  <= expected_n;
      lat_value <= lat_value_n;
      lat_valid <= lat_valid_n;
      lat_ok    <= lat_ok_n;
      err_pulse <= err_pulse_n;
      err_count <= err_count_n;
    end
  end

  // Next-state logic: everything holds unless ce marks a sample
  always_comb begin
    state_n     = state;
    lat_cnt_n   = lat_cnt;
    mark_n      = mark;
    expected_n  = expected;
    lat_value_n = lat_value;
    lat_valid_n = lat_valid;
    lat_ok_n    = lat_ok;
    err_pulse_n = 1'b0;
    err_count_n = err_count;
    // k counts this sample; ref and dut are taken on the same edge, so a
    // D-stage pipeline shows the marked value at k == D
    k           = lat_cnt + LAT_W'(1);

    if (ce) begin
      case (state)
        IDLE: begin
          mark_n    = ref_data;
          lat_cnt_n = '0;
          state_n   = MEASURE;
        end
        MEASURE: begin
          if (dut_data == mark) begin
            lat_value_n = k;
            lat_valid_n = 1'b1;
            lat_ok_n    = (k == DELAY_C);
            expected_n  = mark + N'(1);
            state_n     = TRACK;
          end else if (k == MAX_LAT_C) begin
            lat_value_n = MAX_LAT_C;
            lat_valid_n = 1'b1;
            lat_ok_n    = 1'b0;
            state_n     = FAULT;
          end else begin
            lat_cnt_n = k;
          end
        end
        TRACK: begin
          if (dut_data == expected) begin
            // natural N-bit wrap keeps the ramp rollover error-free
            expected_n = expected + N'(1);
          end else begin
            err_pulse_n = 1'b1;
`ifdef DELAY_LINE_CHECKER_STICKY_EN
            err_count_n = ERR_W'(1);
            state_n     = FAULT;
`else
            if (err_count != ERR_MAX) begin
              err_count_n = err_count + ERR_W'(1);
            end
            // resync on the observed value so one bad sample costs two errors
            expected_n = dut_data + N'(1);
`endif
          end
        end
        FAULT: begin
          state_n = FAULT;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule
